// File: rtl/fnd_scan_decoder_if.sv
// Snoop bus of the 4-digit multiplexed FND display plus the recovered-frame outputs.
// The master drives the display lines; the slave (the decoder) recovers the frame.
interface fnd_scan_decoder_if;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_data;
    logic [13:0] value;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        value_valid;
    logic        frame_err;
    logic        no_signal;

    modport master (
        output fnd_com, fnd_data,
        input  value, digits, dp, value_valid, frame_err, no_signal
    );

    modport slave (
        input  fnd_com, fnd_data,
        output value, digits, dp, value_valid, frame_err, no_signal
    );
endinterface

// File: rtl/fnd_scan_decoder.sv
// Receive-side FND scan decoder: snoops the multiplexed digit-select and segment
// buses, recovers the four scanned digits and decimal points, and converts an
// error-free frame to its binary value (0..9999).
module fnd_scan_decoder #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input logic clk,
    input logic rst,
    fnd_scan_decoder_if.slave bus
);
    localparam int unsigned SCW = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned ICW = $clog2(TIMEOUT_CYCLES + 1);
    // Counter saturates one above the capture point so a long dwell captures only once.
    localparam logic [SCW-1:0] CAP_AT   = SCW'(SETTLE_CYCLES - 1);
    localparam logic [SCW-1:0] STAB_SAT = SCW'(SETTLE_CYCLES);
    localparam logic [ICW-1:0] IDLE_SAT = ICW'(TIMEOUT_CYCLES);
    localparam logic [ICW-1:0] IDLE_HIT = ICW'(TIMEOUT_CYCLES - 1);

    typedef enum logic {WAIT0, WAITN} state_t;

    // Returns {seg_bad, nibble}; dp is not part of the glyph.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        unique case ({1'b1, seg})
            8'hC0: return 5'h00;
            8'hF9: return 5'h01;
            8'hA4: return 5'h02;
            8'hB0: return 5'h03;
            8'h99: return 5'h04;
            8'h92: return 5'h05;
            8'h82: return 5'h06;
            8'hF8: return 5'h07;
            8'h80: return 5'h08;
            8'h90: return 5'h09;
            8'h88: return 5'h0A;
            8'h83: return 5'h0B;
            8'hC6: return 5'h0C;
            8'hA1: return 5'h0D;
            8'h86: return 5'h0E;
            8'h8E: return 5'h0F;
            default: return 5'h10;
        endcase
    endfunction

    // Returns {slot_ok, slot}; only single active-low selects are legal.
    function automatic logic [2:0] com_decode(input logic [3:0] com);
        unique case (com)
            4'b1110: return 3'b100;
            4'b1101: return 3'b101;
            4'b1011: return 3'b110;
            4'b0111: return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    logic [3:0]     com_s1, com_s2, com_p;
    logic [7:0]     data_s1, data_s2, data_p;
    logic [SCW-1:0] stab_cnt;
    logic [ICW-1:0] idle_cnt;
    state_t         state;
    logic [1:0]     expect_slot;
    logic [2:0][3:0] buf_nib;
    logic [2:0]     buf_dp, buf_bad;
    logic [3:0][3:0] conv_nib;
    logic [3:0]     conv_dp, conv_bad;
    logic           conv_busy;
    logic [1:0]     conv_step;
    logic [13:0]    acc, acc_next;
    logic           conv_err;
    logic [13:0]    value_r;
    logic [15:0]    digits_r;
    logic [3:0]     dp_r;
    logic           value_valid_r, frame_err_r, no_signal_r;

    logic [2:0] com_info;
    logic [4:0] seg_info;
    logic [1:0] cap_slot;
    logic [3:0] cap_nib;
    logic       cap_bad, cap_dp, capture, frame_done;

    assign com_info   = com_decode(com_p);
    assign seg_info   = seg_decode(data_p[6:0]);
    assign cap_slot   = com_info[1:0];
    assign cap_nib    = seg_info[3:0];
    assign cap_bad    = seg_info[4];
    assign cap_dp     = ~data_p[7];
    assign capture    = (stab_cnt == CAP_AT) && com_info[2];
    assign frame_done = capture && (state == WAITN) && (cap_slot == expect_slot)
                        && (cap_slot == 2'd3);

    // Two-flop input synchronizers and the dwell-stability counter on the synced pair.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            com_s1   <= '0;
            com_s2   <= '0;
            com_p    <= '0;
            data_s1  <= '0;
            data_s2  <= '0;
            data_p   <= '0;
            stab_cnt <= '0;
        end else begin
            com_s1  <= bus.fnd_com;
            com_s2  <= com_s1;
            com_p   <= com_s2;
            data_s1 <= bus.fnd_data;
            data_s2 <= data_s1;
            data_p  <= data_s2;
            if ({com_s2, data_s2} != {com_p, data_p})
                stab_cnt <= '0;
            else if (stab_cnt != STAB_SAT)
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    // Frame assembly FSM (ones first) with the idle timeout; hands a full frame to conversion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT0;
            expect_slot <= '0;
            buf_nib     <= '0;
            buf_dp      <= '0;
            buf_bad     <= '0;
            conv_nib    <= '0;
            conv_dp     <= '0;
            conv_bad    <= '0;
            idle_cnt    <= '0;
            no_signal_r <= 1'b0;
        end else begin
            if (capture) begin
                idle_cnt    <= '0;
                no_signal_r <= 1'b0;
            end else if (idle_cnt != IDLE_SAT) begin
                idle_cnt <= idle_cnt + 1'b1;
                if (idle_cnt == IDLE_HIT) begin
                    no_signal_r <= 1'b1;
                    state       <= WAIT0;
                end
            end

            if (capture) begin
                unique case (state)
                    WAIT0: begin
                        if (cap_slot == 2'd0) begin
                            buf_nib[0]  <= cap_nib;
                            buf_dp[0]   <= cap_dp;
                            buf_bad[0]  <= cap_bad;
                            expect_slot <= 2'd1;
                            state       <= WAITN;
                        end
                    end
                    WAITN: begin
                        if (cap_slot == expect_slot) begin
                            if (cap_slot == 2'd3) begin
                                conv_nib <= {cap_nib, buf_nib[2], buf_nib[1], buf_nib[0]};
                                conv_dp  <= {cap_dp, buf_dp};
                                conv_bad <= {cap_bad, buf_bad};
                                state    <= WAIT0;
                            end else begin
                                for (int unsigned i = 0; i < 3; i++) begin
                                    if (cap_slot == 2'(i)) begin
                                        buf_nib[i] <= cap_nib;
                                        buf_dp[i]  <= cap_dp;
                                        buf_bad[i] <= cap_bad;
                                    end
                                end
                                expect_slot <= expect_slot + 2'd1;
                            end
                        end else if (cap_slot == 2'd0) begin
                            buf_nib[0]  <= cap_nib;
                            buf_dp[0]   <= cap_dp;
                            buf_bad[0]  <= cap_bad;
                            expect_slot <= 2'd1;
                        end else begin
                            state <= WAIT0;
                        end
                    end
                    default: state <= WAIT0;
                endcase
            end
        end
    end

    // One multiply-accumulate step (thousands first) and the frame error summary.
    always_comb begin
        acc_next = (acc << 3) + (acc << 1) + {10'd0, conv_nib[~conv_step]};
        conv_err = |conv_bad;
        for (int unsigned i = 0; i < 4; i++) begin
            if (conv_nib[i] > 4'd9)
                conv_err = 1'b1;
        end
    end

    // Four-step decimal-to-binary conversion; the last step publishes the frame outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conv_busy     <= 1'b0;
            conv_step     <= '0;
            acc           <= '0;
            value_r       <= '0;
            digits_r      <= '0;
            dp_r          <= '0;
            value_valid_r <= 1'b0;
            frame_err_r   <= 1'b0;
        end else begin
            value_valid_r <= 1'b0;
            if (frame_done) begin
                conv_busy <= 1'b1;
                conv_step <= '0;
                acc       <= '0;
            end else if (conv_busy) begin
                acc       <= acc_next;
                conv_step <= conv_step + 2'd1;
                if (conv_step == 2'd3) begin
                    conv_busy   <= 1'b0;
                    digits_r    <= conv_nib;
                    dp_r        <= conv_dp;
                    frame_err_r <= conv_err;
                    if (!conv_err) begin
                        value_r       <= acc_next;
                        value_valid_r <= 1'b1;
                    end
                end
            end
        end
    end

    // A new frame can never complete while conversion runs when dwell >= 2 cycles.
    a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(frame_done && conv_busy));

    assign bus.value       = value_r;
    assign bus.digits      = digits_r;
    assign bus.dp          = dp_r;
    assign bus.value_valid = value_valid_r;
    assign bus.frame_err   = frame_err_r;
    assign bus.no_signal   = no_signal_r;
endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Directed and randomized bench for fnd_scan_decoder against a frame-level model.
module tb_fnd_scan_decoder;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 300;
    localparam int LAT     = SETTLE + 7;   // drive of slot3 to visible value_valid

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   pulses = 0;
    int   last_pulse_cyc = -1;
    int   last_drive_cyc = 0;

    fnd_scan_decoder_if bus ();

    fnd_scan_decoder #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.value_valid === 1'b1) begin
            pulses = pulses + 1;
            last_pulse_cyc = cyc;
        end
    end

    initial begin
        #500000;
        errors = errors + 1;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Glyph table, index = digit value.
    logic [7:0] SEG [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Frame-level reference model.
    int         part = 0;
    int         m_nib [4];
    logic       m_dp  [4];
    logic       m_bad [4];
    int         exp_value = 0;
    logic [15:0] exp_digits = '0;
    logic [3:0] exp_dp = '0;
    logic       exp_err = 1'b0;
    logic       exp_ns = 1'b0;
    int         exp_pulses = 0;

    task automatic model_capture(input int slot, input logic [7:0] data);
        int nib;
        logic bad;
        logic [6:0] g;
        nib = 0;
        bad = 1'b1;
        for (int k = 0; k < 16; k++) begin
            g = SEG[k][6:0];
            if (g == data[6:0]) begin
                nib = k;
                bad = 1'b0;
            end
        end
        exp_ns = 1'b0;
        if (slot == 0 || (part > 0 && slot == part)) begin
            if (slot == 0) part = 0;
            m_nib[slot] = nib;
            m_dp[slot]  = ~data[7];
            m_bad[slot] = bad;
            part = slot + 1;
            if (part == 4) begin
                part = 0;
                exp_digits = {m_nib[3][3:0], m_nib[2][3:0], m_nib[1][3:0], m_nib[0][3:0]};
                exp_dp = {m_dp[3], m_dp[2], m_dp[1], m_dp[0]};
                exp_err = 1'b0;
                for (int k = 0; k < 4; k++)
                    if (m_bad[k] || m_nib[k] > 9) exp_err = 1'b1;
                if (!exp_err) begin
                    exp_value = m_nib[3] * 1000 + m_nib[2] * 100 + m_nib[1] * 10 + m_nib[0];
                    exp_pulses = exp_pulses + 1;
                end
            end
        end else begin
            part = 0;
        end
    endtask

    task automatic model_reset();
        part = 0;
        exp_value = 0;
        exp_digits = '0;
        exp_dp = '0;
        exp_err = 1'b0;
        exp_ns = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".value"},  32'(bus.value),       32'(exp_value));
        chk({tag, ".digits"}, 32'(bus.digits),      32'(exp_digits));
        chk({tag, ".dp"},     32'(bus.dp),          32'(exp_dp));
        chk({tag, ".err"},    32'(bus.frame_err),   32'(exp_err));
        chk({tag, ".nosig"},  32'(bus.no_signal),   32'(exp_ns));
        chk({tag, ".vv"},     32'(bus.value_valid), 32'(0));
        chk({tag, ".pulses"}, 32'(pulses),          32'(exp_pulses));
    endtask

    task automatic show(input int slot, input logic [7:0] data, input int dwell);
        bus.fnd_com  = ~(4'b0001 << slot);
        bus.fnd_data = data;
        last_drive_cyc = cyc;
        repeat (dwell) @(posedge clk);
        #1;
        if (dwell >= SETTLE) model_capture(slot, data);
    endtask

    task automatic idle(input int n);
        bus.fnd_com  = 4'b1111;
        bus.fnd_data = 8'hFF;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] d0, d1, d2, d3, input int dwell);
        show(0, d0, dwell);
        show(1, d1, dwell);
        show(2, d2, dwell);
        show(3, d3, dwell);
    endtask

    initial begin
        int p0;
        logic [7:0] rd [4];
        bus.fnd_com  = 4'b1111;
        bus.fnd_data = 8'hFF;
        repeat (4) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        idle(3);

        // 1234, nominal dwell, plus latency of the single pulse
        p0 = pulses;
        frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 20);
        check_all("f1234");
        chk("f1234.const", 32'(bus.value), 32'd1234);
        chk("f1234.latency", 32'(last_pulse_cyc - last_drive_cyc), 32'(LAT));
        chk("f1234.onepulse", 32'(pulses - p0), 32'd1);

        // dp lit on tens
        frame(8'h99, 8'h30, 8'hA4, 8'hF9, 20);
        check_all("fdp");
        chk("fdp.const", 32'(bus.dp), 32'b0010);

        // hex digit in hundreds -> error frame, value holds
        frame(8'h99, 8'hB0, 8'h88, 8'hF9, 20);
        check_all("fhex");
        chk("fhex.digits", 32'(bus.digits), 32'h1A34);
        chk("fhex.value", 32'(bus.value), 32'd1234);

        // out-of-order scan, then 5678
        p0 = pulses;
        show(0, 8'h80, 20);
        show(1, 8'hF8, 20);
        show(3, 8'h92, 20);
        show(2, 8'h82, 20);
        idle(15);
        chk("order.nopulse", 32'(pulses - p0), 32'd0);
        frame(8'h80, 8'hF8, 8'h82, 8'h92, 20);
        check_all("f5678");
        chk("f5678.const", 32'(bus.value), 32'd5678);

        // short com glitch inside slot0 dwell is ignored
        show(0, 8'hF9, 10);
        bus.fnd_com = 4'b1011;
        repeat (2) @(posedge clk);
        #1;
        show(0, 8'hF9, 10);
        show(1, 8'hA4, 20);
        show(2, 8'hB0, 20);
        show(3, 8'h99, 20);
        check_all("glitch");
        chk("glitch.latency", 32'(last_pulse_cyc - last_drive_cyc), 32'(LAT));

        // timeout discards partial frame and raises no_signal
        show(0, 8'hC0, 20);
        show(1, 8'hC0, 20);
        idle(TIMEOUT - 50);
        chk("tmo.before", 32'(bus.no_signal), 32'd0);
        idle(70);
        part = 0;
        exp_ns = 1'b1;
        check_all("tmo.after");
        show(2, 8'hC0, 20);
        show(3, 8'hC0, 20);
        idle(15);
        check_all("tmo.partial");

        // reset during conversion
        frame(8'h80, 8'h80, 8'h80, 8'h90, 20);
        check_all("f9888");
        p0 = pulses;
        show(0, 8'h92, 20);
        show(1, 8'h92, 20);
        show(2, 8'h92, 20);
        bus.fnd_com  = 4'b0111;
        bus.fnd_data = 8'h92;
        repeat (SETTLE + 5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rstconv");
        bus.fnd_com  = 4'b1111;
        bus.fnd_data = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(15);
        chk("rstconv.nopulse", 32'(pulses - p0), 32'd0);
        frame(8'h90, 8'h90, 8'h90, 8'h90, 20);
        check_all("f9999");
        chk("f9999.const", 32'(bus.value), 32'd9999);

        // randomized frames
        for (int f = 0; f < 16; f++) begin
            for (int s = 0; s < 4; s++) begin
                if ($urandom_range(5) == 0)
                    rd[s] = 8'($urandom);
                else
                    rd[s] = {1'($urandom), SEG[$urandom_range(9)][6:0]};
            end
            for (int s = 0; s < 4; s++)
                show(s, rd[s], int'($urandom_range(20, 5)));
            idle(14);
            check_all($sformatf("rand%0d", f));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
